// File: rtl/dut_load_ctrl_pkg.sv
// Shared definitions for the counter load controller: FSM states and default sizing.
package dut_load_ctrl_pkg;

   localparam int NDIG_DEF   = 4;
   localparam int WRAP_W_DEF = 8;
   localparam int DIG_W      = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_LOAD,
      ST_CHECK,
      ST_FIN
   } state_e;

endpackage

// File: rtl/dut_load_ctrl_sat_counter.sv
// Saturating event counter with synchronous clear; clear wins over increment.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc_i,
   input  logic         clr_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (clr_i) begin
         cnt_q <= '0;
      end else if (inc_i && (cnt_q != {W{1'b1}})) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/dut_load_ctrl.sv
// Host-side driver for the loadable 4-digit counter: nibble-serial preset load,
// readback verify, clear sequencing and wrap-event counting.
module dut_load_ctrl
   import dut_load_ctrl_pkg::*;
#(
   parameter int NDIG   = NDIG_DEF,
   parameter int WRAP_W = WRAP_W_DEF
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      LD_VALID,
   input  logic [NDIG*DIG_W-1:0]     LD_DATA,
   output logic                      LD_READY,
   input  logic                      RUN,
   input  logic                      CLR_REQ,
   output logic                      nCLR,
   output logic                      nLOAD,
   output logic [$clog2(NDIG)-1:0]   Digit,
   output logic [DIG_W-1:0]          Din,
   output logic                      ENP,
   output logic                      ENT,
   input  logic [NDIG*DIG_W-1:0]     Dout_fb,
   input  logic                      RCO_fb,
   output logic                      DONE,
   output logic                      MISMATCH,
   output logic [WRAP_W-1:0]         WRAPS
);

   localparam int SEL_W  = $clog2(NDIG);
   localparam int WORD_W = NDIG * DIG_W;

   state_e              state_q;
   logic [WORD_W-1:0]   data_q;
   logic [SEL_W-1:0]    dig_q;
   logic [DIG_W-1:0]    din_q;
   logic                nclr_q;
   logic                nload_q;
   logic                done_q;
   logic                mis_q;
   logic                idle;

   assign idle     = (state_q == ST_IDLE);
   assign LD_READY = idle & ~CLR_REQ;
   // Counting is only ever enabled from IDLE, so no count can land between digit writes.
   assign ENP      = RUN & idle;
   assign ENT      = RUN & idle;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= ST_IDLE;
         data_q  <= '0;
         dig_q   <= '0;
         din_q   <= '0;
         nclr_q  <= 1'b1;
         nload_q <= 1'b1;
         done_q  <= 1'b0;
         mis_q   <= 1'b0;
      end else begin
         nclr_q <= 1'b1;
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (CLR_REQ) begin
                  state_q <= ST_CLEAR;
                  nclr_q  <= 1'b0;
               end else if (LD_VALID) begin
                  state_q <= ST_LOAD;
                  data_q  <= LD_DATA;
                  mis_q   <= 1'b0;
                  nload_q <= 1'b0;
                  dig_q   <= '0;
                  din_q   <= LD_DATA[DIG_W-1:0];
               end
            end
            ST_CLEAR: state_q <= ST_IDLE;
            ST_LOAD: begin
               if (dig_q == SEL_W'(NDIG-1)) begin
                  state_q <= ST_CHECK;
                  nload_q <= 1'b1;
                  dig_q   <= '0;
                  din_q   <= '0;
               end else begin
                  dig_q <= dig_q + 1'b1;
                  din_q <= data_q[(int'(dig_q) + 1) * DIG_W +: DIG_W];
               end
            end
            ST_CHECK: begin
               // Last digit was written on the previous edge, so readback is complete here.
               if (Dout_fb != data_q) mis_q <= 1'b1;
               state_q <= ST_FIN;
               done_q  <= 1'b1;
            end
            ST_FIN:  state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign nCLR     = nclr_q;
   assign nLOAD    = nload_q;
   assign Digit    = dig_q;
   assign Din      = din_q;
   assign DONE     = done_q;
   assign MISMATCH = mis_q;

   sat_counter #(.W(WRAP_W)) u_wraps (
      .clk   (CLK),
      .rst   (RST),
      .inc_i (RCO_fb & ENT),
      .clr_i (idle & CLR_REQ),
      .cnt_o (WRAPS)
   );

endmodule
